instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/multicore_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared fetch front-end types: fetch FSM states and fetch-buffer entry layout.
package multicore_pkg;
  localparam int INST_SIZE     = 32;
  // pc field is sized for the widest supported ADDR_SIZE; narrower PCs are zero-extended
  localparam int PC_FIELD_SIZE = 64;

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} fetch_state_t;

  typedef struct packed {
    logic [PC_FIELD_SIZE-1:0] pc;
    logic [INST_SIZE-1:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer of fetch_entry_t; head valid the cycle after a push, flush empties it at once.
// Pop ignored when empty; push on full is taken only alongside a same-cycle pop.
module fetch_fifo
  import multicore_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  fetch_entry_t  i_push_dat,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_valid,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);
  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Head reads as zero when empty so stale storage never leaks onto the outputs
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding cache request, responses queued in fetch_fifo for decode.
// Head valid one cycle after a response; a request issues only if the buffer keeps a free slot.
module instr_fetch
  import multicore_pkg::*;
#(
  parameter int                   ADDR_SIZE  = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 4
) (
  input  logic                 i_aclk,
  input  logic                 i_areset,
  output logic                 o_req,
  output logic [ADDR_SIZE-1:0] o_addr,
  input  logic                 i_instr_valid,
  input  logic [INST_SIZE-1:0] i_instruction,
  input  logic                 i_redirect,
  input  logic [ADDR_SIZE-1:0] i_redirect_pc,
  output logic                 o_valid,
  output logic [INST_SIZE-1:0] o_instr,
  output logic [ADDR_SIZE-1:0] o_pc,
  input  logic                 i_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t         r_state;
  fetch_state_t         w_state_nxt;
  logic [ADDR_SIZE-1:0] r_pc;
  logic [ADDR_SIZE-1:0] w_pc_nxt;
  logic [ADDR_SIZE-1:0] w_target;
  logic                 r_live;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_room;
  logic [CW-1:0]        w_count;
  logic [CW:0]          w_count_after;
  fetch_entry_t         w_push_dat;
  fetch_entry_t         w_head;

  assign w_target      = i_redirect_pc & ~(ADDR_SIZE'(3));
  assign w_pop         = o_valid && i_ready;
  assign w_push        = (r_state == WAIT) && i_instr_valid && !i_redirect;
  assign w_flush       = i_redirect && (r_state != FLUSH);
  assign w_count_after = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_room        = w_count_after < (CW+1)'(FIFO_DEPTH);
  assign w_push_dat    = '{pc: PC_FIELD_SIZE'(r_pc), instr: i_instruction};

  // r_live holds off the first request for one cycle after reset release
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (i_redirect) w_pc_nxt = w_target;
    case (r_state)
      IDLE: begin
        if (!i_redirect && r_live && w_room) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (i_redirect) begin
          w_state_nxt = i_instr_valid ? IDLE : FLUSH;
        end else if (i_instr_valid) begin
          w_pc_nxt    = r_pc + ADDR_SIZE'(4);
          w_state_nxt = w_room ? WAIT : IDLE;
        end
      end
      FLUSH: begin
        if (i_instr_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req  = (r_state == WAIT);
    o_addr = r_pc;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk      (i_aclk),
    .i_rst      (i_areset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_valid    (o_valid),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  assign o_instr = w_head.instr;
  assign o_pc    = ADDR_SIZE'(w_head.pc);
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a queue-based reference model, plus directed corner scenarios.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC  = 32'h0;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam int          DEPTH   = 4;

  logic        clk, rst, rst2;
  logic        o_req, o_valid, i_instr_valid, i_redirect, i_ready;
  logic [31:0] o_addr, o_instr, o_pc, i_instruction, i_redirect_pc;
  logic        o2_req, o2_valid, i2_valid;
  logic [31:0] o2_addr, o2_instr, o2_pc;

  instr_fetch #(.ADDR_SIZE(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_aclk(clk), .i_areset(rst), .o_req(o_req), .o_addr(o_addr),
    .i_instr_valid(i_instr_valid), .i_instruction(i_instruction),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready));

  instr_fetch #(.ADDR_SIZE(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .i_aclk(clk), .i_areset(rst2), .o_req(o2_req), .o_addr(o2_addr),
    .i_instr_valid(i2_valid), .i_instruction(32'h1357_9BDF),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_valid(o2_valid), .o_instr(o2_instr), .o_pc(o2_pc), .i_ready(1'b1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: expected buffer contents, fetch pc, request-outstanding and stale-response flags
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_req, m_drop, m_live;

  function automatic void m_reset();
    m_q.delete(); m_pc = RST_PC; m_req = 0; m_drop = 0; m_live = 0;
  endfunction

  function automatic void m_step(bit v, logic [31:0] ins, bit rd, logic [31:0] rpc, bit rdy);
    bit pop;
    pop = (m_q.size() > 0) && rdy;
    if (rd) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      if (m_req) begin
        m_req  = 0;
        m_drop = !v;
      end else if (m_drop && v) m_drop = 0;
    end else begin
      if (pop) m_q.delete(0);
      if (m_req) begin
        if (v) begin
          m_q.push_back('{pc: m_pc, ins: ins});
          m_pc  = m_pc + 32'd4;
          m_req = (m_q.size() < DEPTH);
        end
      end else if (m_drop) begin
        if (v) m_drop = 0;
      end else m_req = m_live && (m_q.size() < DEPTH);
    end
    m_live = 1;
  endfunction

  task automatic cmp_all();
    chk("o_req", 32'(o_req), 32'(m_req));
    chk("o_addr", o_addr, m_pc);
    chk("o_valid", 32'(o_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("o_pc", o_pc, m_q[0].pc);
      chk("o_instr", o_instr, m_q[0].ins);
    end
  endtask

  // Cache responder: one response per request after lat cycles; still answers abandoned requests
  int          lat_min = 1, lat_max = 1, rsp_cnt = 0;
  bit          rsp_busy = 0, force_v = 0;
  logic [31:0] acc[$];

  task automatic cyc(input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          v;
    logic [31:0] ins;
    v = 0;
    if (force_v) begin
      v = 1; force_v = 0;
    end else begin
      if (!rsp_busy && m_req) begin
        rsp_busy = 1; rsp_cnt = $urandom_range(lat_max, lat_min);
      end
      if (rsp_busy) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin v = 1; rsp_busy = 0; end
      end
    end
    ins = $urandom;
    if (v && o_req) acc.push_back(o_addr);
    i_instr_valid = v; i_instruction = ins; i_redirect = rd; i_redirect_pc = rpc; i_ready = rdy;
    m_step(v, ins, rd, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    rst = 1;
    i_instr_valid = 0; i_instruction = 0; i_redirect = 0; i_redirect_pc = 0; i_ready = 0;
    @(posedge clk);
    @(negedge clk);
    m_reset(); rsp_busy = 0; force_v = 0; acc.delete();
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_addr", o_addr, RST_PC);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    rst = 0;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Wrap instance: answers every request on the next edge, logs addresses and first head
  logic [31:0] q2[$];
  bit          h2_seen = 0;
  logic [31:0] h2_pc, h2_ins;
  initial begin
    i2_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst2 && o2_req) begin
        if (q2.size() < 4) q2.push_back(o2_addr);
        i2_valid = 1;
      end else i2_valid = 0;
      if (o2_valid && !h2_seen) begin
        h2_seen = 1; h2_pc = o2_pc; h2_ins = o2_instr;
      end
    end
  end

  initial begin
    int          first_req;
    bit          ok, seen8, pend;
    logic [31:0] a;
    rst2 = 1;

    // Back-to-back fetch, latency 1, decode always ready
    do_reset();
    rst2 = 0;
    first_req = -1;
    for (int n = 1; n <= 10; n++) begin
      cyc(0, 0, 1);
      if (o_req && first_req < 0) first_req = n;
    end
    chk("first_req_edge", first_req, 2);
    chk("seq_len", 32'(acc.size() >= 3), 32'd1);
    chk("seq0", acc[0], 32'h0);
    chk("seq1", acc[1], 32'h4);
    chk("seq2", acc[2], 32'h8);
    chk("wrap_len", 32'(q2.size() >= 2), 32'd1);
    chk("wrap_addr0", q2[0], WRAP_PC);
    chk("wrap_addr1", q2[1], 32'h0);
    chk("wrap_head_seen", 32'(h2_seen), 32'd1);
    chk("wrap_head_pc", h2_pc, WRAP_PC);
    chk("wrap_head_ins", h2_ins, 32'h1357_9BDF);

    // Decode stalled: buffer fills, requests stop, resume at 0x10
    do_reset();
    for (int n = 0; n < 14; n++) cyc(0, 0, 0);
    chk("full_pushes", acc.size(), 4);
    chk("full_req", 32'(o_req), 32'd0);
    chk("full_valid", 32'(o_valid), 32'd1);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      cyc(0, 0, 1);
      if (o_req) ok = 1;
    end
    chk("resume_seen", 32'(ok), 32'd1);
    chk("resume_addr", o_addr, 32'h10);

    // Redirect while waiting at 0x8; stale response two cycles later
    do_reset();
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (m_req && !rsp_busy && m_pc == 32'h8) ok = 1;
      else cyc(0, 0, 1);
    end
    chk("wait8_reached", 32'(ok), 32'd1);
    lat_min = 3; lat_max = 3;
    cyc(1, 32'h100, 1);
    seen8 = 0; ok = 0; a = 0;
    for (int k = 0; k < 15 && !ok; k++) begin
      cyc(0, 0, 1);
      if (o_valid && o_pc == 32'h8) seen8 = 1;
      if (o_req) begin ok = 1; a = o_addr; end
    end
    chk("redir_req_seen", 32'(ok), 32'd1);
    chk("redir_addr", a, 32'h100);
    chk("no_pc8", 32'(seen8), 32'd0);

    // Redirect to unaligned target coincident with a response
    do_reset();
    lat_min = 1; lat_max = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (m_req && !rsp_busy && m_pc == 32'h4) ok = 1;
      else cyc(0, 0, 0);
    end
    chk("wait4_reached", 32'(ok), 32'd1);
    cyc(1, 32'h203, 0);
    chk("coinc_flush_valid", 32'(o_valid), 32'd0);
    ok = 0; a = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      cyc(0, 0, 1);
      if (o_req) begin ok = 1; a = o_addr; end
    end
    chk("coinc_addr", a, 32'h200);

    // Reset mid-WAIT with the abandoned response arriving just after release
    do_reset();
    lat_min = 3; lat_max = 3;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (m_req && rsp_busy) ok = 1;
      else cyc(0, 0, 1);
    end
    chk("midwait_reached", 32'(ok), 32'd1);
    do_reset();
    force_v = 1;
    ok = 0; a = 32'hDEAD_BEEF;
    for (int n = 1; n <= 4; n++) begin
      cyc(0, 0, 1);
      chk("stale_valid", 32'(o_valid), 32'd0);
      if (o_req && !ok) begin ok = 1; a = o_addr; end
    end
    chk("stale_first_addr", a, RST_PC);

    // Random traffic: variable latency, decode stalls, redirects (some near the wrap point), resets
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int n = 0; n < 3000; n++) begin
      bit          rd, rdy;
      logic [31:0] rpc;
      if (n % 997 == 500) begin
        pend = rsp_busy;
        do_reset();
        force_v = pend;
      end
      rd  = ($urandom_range(99, 0) < 4);
      rpc = ($urandom_range(1, 0) == 1) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF));
      rdy = ($urandom_range(99, 0) < 65);
      cyc(rd, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
